prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/loader_pkg.sv | 23 ++
 rtl/prog_loader_word_assembler.sv | 31 +++
 rtl/prog_loader.sv | 129 ++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared constants for the UART program loader.
// State encodings and image-format sizes.
package loader_pkg;

   localparam logic [2:0] ST_CNT_LO = 3'd0;
   localparam logic [2:0] ST_CNT_HI = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_CSUM   = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;
   localparam logic [2:0] ST_ERR    = 3'd5;

   localparam int HDR_BYTES  = 2;
   localparam int CNT_W      = 8 * HDR_BYTES;
   localparam int CSUM_W     = 8;
   localparam int WORD_BYTES = 4;
   localparam int BCNT_W     = $clog2(WORD_BYTES);

   function automatic logic is_loading(input logic [2:0] s);
      return (s == ST_CNT_LO) || (s == ST_CNT_HI) ||
             (s == ST_DATA)   || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Shifts payload bytes into a little-endian 32-bit word.
// done_o marks the enable cycle that supplies the final byte.
module word_assembler
   import loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        done_o
);

   logic [BCNT_W-1:0] bcnt_q;
   logic [23:0]       shreg_q;

   // Newest byte lands on top so the first byte ends in bits 7:0.
   assign word_o = {byte_i, shreg_q};
   assign done_o = en_i && (bcnt_q == BCNT_W'(WORD_BYTES - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bcnt_q  <= '0;
         shreg_q <= '0;
      end else if (en_i) begin
         bcnt_q  <= bcnt_q + 1'b1;
         shreg_q <= word_o[31:8];
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: pulls an image from the UART FIFO into instruction
// memory, verifies the XOR checksum and then releases the CPU.
module prog_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W    = 9,
   parameter int MAX_WORDS = 512
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_empty,
   input  logic [7:0]        r_data,
   output logic              rd_uart,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset,
   output logic              load_done,
   output logic              load_err
);

   localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_WORDS);

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  wcnt_q, wcnt_d;
   logic [CSUM_W-1:0] xor_q, xor_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              done_q, err_q, cpurst_q;

   logic              wa_en;
   logic              wa_done;
   logic [31:0]       wa_word;
   logic [CNT_W-1:0]  n_full;

   assign rd_uart    = !rx_empty && is_loading(state_q);
   assign wa_en      = rd_uart && (state_q == ST_DATA);
   assign n_full     = {r_data, cnt_q[7:0]};

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_reset  = cpurst_q;
   assign load_done  = done_q;
   assign load_err   = err_q;

   word_assembler u_wa (
      .clk_i  (clk),
      .rst_i  (reset),
      .en_i   (wa_en),
      .byte_i (r_data),
      .word_o (wa_word),
      .done_o (wa_done)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      xor_d   = xor_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (rd_uart) begin
         unique case (state_q)
            ST_CNT_LO: begin
               cnt_d   = {8'h00, r_data};
               xor_d   = xor_q ^ r_data;
               state_d = ST_CNT_HI;
            end
            ST_CNT_HI: begin
               cnt_d = n_full;
               xor_d = xor_q ^ r_data;
               if (n_full > MAX_N)
                  state_d = ST_ERR;
               else if (n_full == '0)
                  state_d = ST_CSUM;
               else
                  state_d = ST_DATA;
            end
            ST_DATA: begin
               xor_d = xor_q ^ r_data;
               if (wa_done) begin
                  we_d    = 1'b1;
                  addr_d  = wcnt_q[ADDR_W-1:0];
                  wdata_d = wa_word;
                  wcnt_d  = wcnt_q + 1'b1;
                  if (wcnt_q + 1'b1 == cnt_q)
                     state_d = ST_CSUM;
               end
            end
            ST_CSUM: begin
               state_d = (r_data == xor_q) ? ST_DONE : ST_ERR;
            end
            default: ;
         endcase
      end
   end

   // Status flags decode the next state so they line up with state_q.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_CNT_LO;
         cnt_q    <= '0;
         wcnt_q   <= '0;
         xor_q    <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         cpurst_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wcnt_q   <= wcnt_d;
         xor_q    <= xor_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         done_q   <= (state_d == ST_DONE);
         err_q    <= (state_d == ST_ERR);
         cpurst_q <= (state_d != ST_DONE);
      end
   end

endmodule
